reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised reset controller placed between the PLL and the SoC core in each board top. It filters the PLL lock signal, holds every reset channel asserted for a programmable delay once the PLL lock is stable, then releases the channels one by one in a staggered order. It re-sequences automatically on PLL lock loss or on a software reset request, and it records the cause of the last reset.

## Interface
- LOCK_FILTER, 4: consecutive high `pll_locked` samples required before `pll_stable` asserts (≥1)
- RELEASE_DELAY, 128: cycles from DELAY entry to channel 0 release
- CHANNELS, 3: number of reset outputs (1..8)
- STAGGER, 16: cycles between successive channel releases
- SW_HOLD, 16: minimum cycles all channels stay asserted after a software request (≥1)
- clk_core  in  1  core clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- pll_locked  in  1  raw PLL LOCK; asynchronous to nothing, sampled on clk_core
- sw_reset_req  in  1  synchronous level request for a full re-sequence
- chan_reset_n  out  CHANNELS  per-domain active-low resets; bit 0 is released first
- pll_stable  out  1  filtered lock
- all_released  out  1  high in RUN only
- reset_cause  out  2  0=EXT, 1=LOCK_LOSS, 2=SW; 3 is never produced
- lock_loss_count  out  8  saturating count of lock-loss events since reset_n

## Operation
- Asynchronous reset (reset_n low): state LOCK; chan_reset_n=0, pll_stable=0, all_released=0, reset_cause=0, lock_loss_count=0, all counters 0.
- Lock filter: a LOCK_FILTER-bit shift register samples pll_locked. pll_stable is registered as the AND of all window bits.
- FSM states:
  - LOCK: all channels asserted. Moves to DELAY on the first edge at which the registered pll_stable is 1. The sequence counter clears on entry.
  - DELAY: the counter increments each cycle and saturates at D+(CHANNELS-1)*S; it never wraps. Channel k is released at the edge that ends the cycle in which counter == RELEASE_DELAY + k*STAGGER. Once the last channel is released the FSM moves to RUN. Released channels stay released.
  - RUN: all channels deasserted and all_released=1.
  - HOLD: all channels asserted. The counter counts SW_HOLD cycles while sw_reset_req is low; sw_reset_req high restarts the count. At the end the FSM moves to DELAY if pll_stable=1, otherwise to LOCK.
- Lock loss: pll_stable falling while in DELAY, RUN or HOLD does the following at the next edge: all channels asserted, reset_cause=1, lock_loss_count +1 (saturates at 255), state LOCK.
- Software request: sw_reset_req=1 in DELAY or RUN does the following at the next edge: all channels asserted, reset_cause=2, state HOLD. In LOCK the request is ignored.
- Simultaneous lock loss and software request: lock loss wins (cause=1, state LOCK).
- reset_cause keeps its value until the next event of a different kind overwrites it.
- Counter width: $clog2(max(RELEASE_DELAY+(CHANNELS-1)*STAGGER, SW_HOLD)+1).

## Timing
- pll_stable rises on the (LOCK_FILTER+1)th consecutive edge that samples pll_locked high.
- pll_stable falls on the edge after the first edge that samples pll_locked low.
- Channel k rises RELEASE_DELAY + k*STAGGER + 2 edges after pll_stable rises.
- all_released rises on the same edge as the last channel.
- Lock loss or software request: channels drop one edge after the FSM observes the condition.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- reset_n assertion mid-sequence clears everything immediately. Deassertion restarts from LOCK.

## Structure
- A shared package `reset_seq_pkg` holds:
  - the state enum (LOCK, DELAY, HOLD, RUN)
  - the cause encodings CAUSE_EXT, CAUSE_LOCK_LOSS, CAUSE_SW
- One sub-module, `lock_filter`: the shift window plus the registered pll_stable, parametrised by LOCK_FILTER.
- The FSM, sequence counter and channel registers live in `reset_sequencer`.

## Test plan
Default parameters for all scenarios: LOCK_FILTER=4, RELEASE_DELAY=8, CHANNELS=3, STAGGER=4, SW_HOLD=2.
- Power-up: reset_n released, pll_locked=1 from edge 1 -> pll_stable rises at edge 5; chan_reset_n goes 001 at edge 15, 011 at edge 19, 111 at edge 23; all_released=1 at edge 23; reset_cause=0.
- Glitchy lock: pll_locked pattern 1,1,1,0,1,1,1,1 -> pll_stable stays 0 until 5 consecutive highs are seen after the 0; no channel is released early.
- Lock loss in RUN: pll_locked low for 1 cycle -> channels 000 two edges after the low sample; reset_cause=1; lock_loss_count=1; full re-sequence with the same offsets once lock returns.
- Software reset in RUN: sw_reset_req high for 1 cycle -> channels 000 next edge, reset_cause=2; HOLD 2 cycles; channel 0 released 8+1 edges after DELAY entry.
- Simultaneous: sw_reset_req and lock loss in the same cycle -> reset_cause=1, state LOCK; 256 lock losses -> lock_loss_count stays 255.
- Async reset mid-DELAY: reset_n pulsed low between edges 17 and 18 -> all outputs 0 immediately; sequence restarts from LOCK.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and encodings for the reset sequencer slice.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    LOCK  = 2'd0,
    DELAY = 2'd1,
    HOLD  = 2'd2,
    RUN   = 2'd3
  } seq_state_e;

  localparam logic [1:0] CAUSE_EXT       = 2'd0;
  localparam logic [1:0] CAUSE_LOCK_LOSS = 2'd1;
  localparam logic [1:0] CAUSE_SW        = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_filter.sv
// Debounces the raw PLL lock: pll_stable is the registered AND of the last
// LOCK_FILTER samples of pll_locked.
module lock_filter #(
  parameter int LOCK_FILTER = 4
) (
  input  logic clk_core,
  input  logic reset_n,
  input  logic pll_locked,
  output logic pll_stable
);

  logic [LOCK_FILTER-1:0] window_q;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      window_q   <= '0;
      pll_stable <= 1'b0;
    end else begin
      window_q   <= (window_q << 1) | LOCK_FILTER'(pll_locked);
      pll_stable <= &window_q;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset controller: waits for a stable PLL lock, then releases the reset
// channels one at a time; re-sequences on lock loss or software request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int LOCK_FILTER   = 4,
  parameter int RELEASE_DELAY = 128,
  parameter int CHANNELS      = 3,
  parameter int STAGGER       = 16,
  parameter int SW_HOLD       = 16
) (
  input  logic                clk_core,
  input  logic                reset_n,
  input  logic                pll_locked,
  input  logic                sw_reset_req,
  output logic [CHANNELS-1:0] chan_reset_n,
  output logic                pll_stable,
  output logic                all_released,
  output logic [1:0]          reset_cause,
  output logic [7:0]          lock_loss_count
);

  localparam int SEQ_END = RELEASE_DELAY + (CHANNELS - 1) * STAGGER;
  localparam int CNT_W   = $clog2(max_int(SEQ_END, SW_HOLD) + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SEQ_END);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SW_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  seq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] chan_q, chan_d;
  logic                all_rel_q, all_rel_d;
  logic [1:0]          cause_q, cause_d;
  logic [7:0]          llc_q, llc_d;
  logic                lock_lost;
  logic                sw_event;

  lock_filter #(
    .LOCK_FILTER (LOCK_FILTER)
  ) u_lock_filter (
    .clk_core   (clk_core),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .pll_stable (pll_stable)
  );

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= LOCK;
      cnt_q     <= '0;
      chan_q    <= '0;
      all_rel_q <= 1'b0;
      cause_q   <= CAUSE_EXT;
      llc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      chan_q    <= chan_d;
      all_rel_q <= all_rel_d;
      cause_q   <= cause_d;
      llc_q     <= llc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    chan_d    = chan_q;
    all_rel_d = 1'b0;
    cause_d   = cause_q;
    llc_d     = llc_q;
    // pll_stable can only be low outside LOCK right after it fell
    lock_lost = (state_q != LOCK) && !pll_stable;
    sw_event  = sw_reset_req && ((state_q == DELAY) || (state_q == RUN));

    case (state_q)
      LOCK: begin
        chan_d = '0;
        if (pll_stable) begin
          state_d = DELAY;
          cnt_d   = '0;
        end
      end
      DELAY: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        for (int k = 0; k < CHANNELS; k++) begin
          if (cnt_q == CNT_W'(RELEASE_DELAY + k * STAGGER)) chan_d[k] = 1'b1;
        end
        if (chan_d[CHANNELS-1]) begin
          state_d   = RUN;
          all_rel_d = 1'b1;
        end
      end
      RUN: begin
        chan_d    = '1;
        all_rel_d = 1'b1;
      end
      HOLD: begin
        chan_d = '0;
        if (sw_reset_req) begin
          cnt_d = '0;
        end else if (cnt_q >= HOLD_LAST) begin
          state_d = pll_stable ? DELAY : LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOCK;
        chan_d  = '0;
        cnt_d   = '0;
      end
    endcase

    // Lock loss takes priority over a concurrent software request
    if (lock_lost) begin
      state_d   = LOCK;
      cnt_d     = '0;
      chan_d    = '0;
      all_rel_d = 1'b0;
      cause_d   = CAUSE_LOCK_LOSS;
      if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
    end else if (sw_event) begin
      state_d   = HOLD;
      cnt_d     = '0;
      chan_d    = '0;
      all_rel_d = 1'b0;
      cause_d   = CAUSE_SW;
    end
  end

  assign chan_reset_n    = chan_q;
  assign all_released    = all_rel_q;
  assign reset_cause     = cause_q;
  assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with LOCK_FILTER=4, RELEASE_DELAY=8,
// CHANNELS=3, STAGGER=4, SW_HOLD=2.
module tb_reset_sequencer;

  logic       clk_core = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       sw_reset_req;
  logic [2:0] chan_reset_n;
  logic       pll_stable;
  logic       all_released;
  logic [1:0] reset_cause;
  logic [7:0] lock_loss_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         n;
    logic       locked;
    logic       sw;
    logic       stable;
    logic [2:0] chan;
    logic       all_rel;
    logic [1:0] cause;
    logic [7:0] llc;
  } vec_t;

  vec_t tbl[$];

  reset_sequencer #(
    .LOCK_FILTER   (4),
    .RELEASE_DELAY (8),
    .CHANNELS      (3),
    .STAGGER       (4),
    .SW_HOLD       (2)
  ) dut (
    .clk_core        (clk_core),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .sw_reset_req    (sw_reset_req),
    .chan_reset_n    (chan_reset_n),
    .pll_stable      (pll_stable),
    .all_released    (all_released),
    .reset_cause     (reset_cause),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk_core = ~clk_core;

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] ch, input logic st,
                         input logic al, input logic [1:0] c, input logic [7:0] ll);
    chk({tag, " chan"},   32'(chan_reset_n),    32'(ch));
    chk({tag, " stable"}, 32'(pll_stable),      32'(st));
    chk({tag, " allrel"}, 32'(all_released),    32'(al));
    chk({tag, " cause"},  32'(reset_cause),     32'(c));
    chk({tag, " llc"},    32'(lock_loss_count), 32'(ll));
  endtask

  function automatic vec_t mk(input int n, input logic l, input logic s, input logic st,
                              input logic [2:0] ch, input logic al, input logic [1:0] c,
                              input logic [7:0] ll);
    vec_t v;
    v.n = n; v.locked = l; v.sw = s; v.stable = st;
    v.chan = ch; v.all_rel = al; v.cause = c; v.llc = ll;
    return v;
  endfunction

  initial begin
    // Edge numbers in the comments count from the reset_n release
    tbl.push_back(mk(4, 1, 0, 0, 3'b000, 0, 0, 0));  // e4
    tbl.push_back(mk(1, 1, 0, 1, 3'b000, 0, 0, 0));  // e5
    tbl.push_back(mk(9, 1, 0, 1, 3'b000, 0, 0, 0));  // e14
    tbl.push_back(mk(1, 1, 0, 1, 3'b001, 0, 0, 0));  // e15
    tbl.push_back(mk(3, 1, 0, 1, 3'b001, 0, 0, 0));  // e18
    tbl.push_back(mk(1, 1, 0, 1, 3'b011, 0, 0, 0));  // e19
    tbl.push_back(mk(3, 1, 0, 1, 3'b011, 0, 0, 0));  // e22
    tbl.push_back(mk(1, 1, 0, 1, 3'b111, 1, 0, 0));  // e23
    tbl.push_back(mk(5, 1, 0, 1, 3'b111, 1, 0, 0));  // e28
    tbl.push_back(mk(1, 0, 0, 1, 3'b111, 1, 0, 0));  // e29 low sample
    tbl.push_back(mk(1, 1, 0, 0, 3'b111, 1, 0, 0));  // e30
    tbl.push_back(mk(1, 1, 0, 0, 3'b000, 0, 1, 1));  // e31 lock loss
    tbl.push_back(mk(2, 1, 0, 0, 3'b000, 0, 1, 1));  // e33
    tbl.push_back(mk(1, 1, 0, 1, 3'b000, 0, 1, 1));  // e34
    tbl.push_back(mk(9, 1, 0, 1, 3'b000, 0, 1, 1));  // e43
    tbl.push_back(mk(1, 1, 0, 1, 3'b001, 0, 1, 1));  // e44
    tbl.push_back(mk(4, 1, 0, 1, 3'b011, 0, 1, 1));  // e48
    tbl.push_back(mk(4, 1, 0, 1, 3'b111, 1, 1, 1));  // e52
    tbl.push_back(mk(3, 1, 0, 1, 3'b111, 1, 1, 1));  // e55
    tbl.push_back(mk(1, 1, 1, 1, 3'b000, 0, 2, 1));  // e56 sw request
    tbl.push_back(mk(1, 1, 0, 1, 3'b000, 0, 2, 1));  // e57
    tbl.push_back(mk(9, 1, 0, 1, 3'b000, 0, 2, 1));  // e66
    tbl.push_back(mk(1, 1, 0, 1, 3'b001, 0, 2, 1));  // e67
    tbl.push_back(mk(4, 1, 0, 1, 3'b011, 0, 2, 1));  // e71
    tbl.push_back(mk(4, 1, 0, 1, 3'b111, 1, 2, 1));  // e75
    tbl.push_back(mk(1, 0, 0, 1, 3'b111, 1, 2, 1));  // e76 low sample
    tbl.push_back(mk(1, 1, 0, 0, 3'b111, 1, 2, 1));  // e77
    tbl.push_back(mk(1, 1, 1, 0, 3'b000, 0, 1, 2));  // e78 loss + sw together
    tbl.push_back(mk(3, 1, 1, 1, 3'b000, 0, 1, 2));  // e81 sw ignored in LOCK
    tbl.push_back(mk(1, 1, 0, 1, 3'b000, 0, 1, 2));  // e82 DELAY entry
    tbl.push_back(mk(8, 1, 0, 1, 3'b000, 0, 1, 2));  // e90
    tbl.push_back(mk(1, 1, 0, 1, 3'b001, 0, 1, 2));  // e91
    tbl.push_back(mk(1, 1, 1, 1, 3'b000, 0, 2, 2));  // e92 sw in DELAY
    tbl.push_back(mk(1, 1, 1, 1, 3'b000, 0, 2, 2));  // e93 HOLD restart
    tbl.push_back(mk(10, 1, 0, 1, 3'b000, 0, 2, 2)); // e103
    tbl.push_back(mk(1, 1, 0, 1, 3'b001, 0, 2, 2));  // e104
    tbl.push_back(mk(4, 1, 0, 1, 3'b011, 0, 2, 2));  // e108
    tbl.push_back(mk(4, 1, 0, 1, 3'b111, 1, 2, 2));  // e112

    reset_n      = 1'b1;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_all("reset_async", 3'b000, 0, 0, 0, 0);
    step();
    step();
    chk_all("reset_held", 3'b000, 0, 0, 0, 0);

    reset_n    = 1'b1;
    pll_locked = 1'b1;
    foreach (tbl[i]) begin
      pll_locked   = tbl[i].locked;
      sw_reset_req = tbl[i].sw;
      repeat (tbl[i].n) step();
      chk_all($sformatf("vec%0d", i), tbl[i].chan, tbl[i].stable, tbl[i].all_rel,
              tbl[i].cause, tbl[i].llc);
    end
    sw_reset_req = 1'b0;

    // Glitchy lock after a fresh reset: 1,1,1,0 then highs
    reset_n = 1'b0;
    #1 chk_all("glitch_rst", 3'b000, 0, 0, 0, 0);
    reset_n    = 1'b1;
    pll_locked = 1'b1;
    repeat (3) step();
    pll_locked = 1'b0;
    step();                                   // e4 samples low
    pll_locked = 1'b1;
    repeat (4) step();                        // e8: highs at e5..e8
    chk("glitch_e8 stable", 32'(pll_stable), 32'd0);
    step();                                   // e9: fifth high edge
    chk("glitch_e9 stable", 32'(pll_stable), 32'd1);
    repeat (9) step();                        // e18
    chk("glitch_e18 chan", 32'(chan_reset_n), 32'd0);
    step();                                   // e19 = 9 + 10
    chk("glitch_e19 chan", 32'(chan_reset_n), 32'b001);

    // Asynchronous reset mid-DELAY
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    repeat (17) step();
    chk("mid_e17 chan", 32'(chan_reset_n), 32'b001);
    #2 reset_n = 1'b0;
    #1 chk_all("mid_async", 3'b000, 0, 0, 0, 0);
    #1 reset_n = 1'b1;
    repeat (5) step();
    chk_all("restart_e5", 3'b000, 1, 0, 0, 0);
    repeat (9) step();
    chk("restart_e14 chan", 32'(chan_reset_n), 32'b000);
    step();
    chk("restart_e15 chan", 32'(chan_reset_n), 32'b001);
    repeat (8) step();
    chk_all("restart_e23", 3'b111, 1, 1, 0, 0);

    // Repeated lock losses: one per 10-cycle loop, count saturates at 255
    for (int it = 1; it <= 260; it++) begin
      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
      repeat (9) step();
      if (it == 10)  chk("sat_llc10",  32'(lock_loss_count), 32'd10);
      if (it == 255) chk("sat_llc255", 32'(lock_loss_count), 32'd255);
    end
    chk("sat_llc_final", 32'(lock_loss_count), 32'd255);
    chk("sat_cause",     32'(reset_cause),     32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
